fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side output stage placed directly downstream of the dual-clock FIFO, in the read clock domain.
- Converts the FIFO's raw read port (rempty / read-increment / combinational rdata) into a registered valid/ready stream.
- Uses a 2-entry skid buffer, so there is no combinational path from m_ready to the FIFO read-increment.
- Sustains 1 beat/cycle when the FIFO is non-empty and the consumer is ready.

Parameters:
DSIZE, 8, data word width (matches FIFO data width)

Ports:
rclk  input  1  read-domain clock; all state on rising edge
rrst  input  1  asynchronous active-high reset
fifo_rempty  input  1  FIFO empty flag (already rclk-synchronous)
fifo_rdata  input  DSIZE  FIFO head word, valid whenever fifo_rempty=0
fifo_rinc  output  1  FIFO read increment; the head word is consumed at the rclk edge where this is 1
flush  input  1  synchronous discard of buffered beats
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  DSIZE  stream data
occupancy  output  2  beats held in the buffer (0..2)

Behaviour:
- Interface: one clock (rclk); reset rrst is asynchronous and active-high.
- Storage:
  - buf0/buf1 DSIZE-bit registers.
  - 1-bit wr_sel and rd_sel pointers.
  - 2-bit count: states EMPTY(0), ONE(1), FULL(2); value 3 is never reachable.
- Reset (async assert, sync release):
  - count=0, wr_sel=rd_sel=0, buf0=buf1=0.
  - m_valid=0, m_data=0, occupancy=0.
  - fifo_rinc is forced 0 combinationally while rrst=1.
- push = fifo_rinc = ~rrst & ~fifo_rempty & ~flush & (count!=2).
  - Depends only on registered count, never on m_ready.
- pop = m_valid & m_ready & ~flush.
- On push: buf[wr_sel] <= fifo_rdata; wr_sel toggles.
- On pop: rd_sel toggles.
- count_next = count + push - pop.
  - Simultaneous push+pop in ONE stays in ONE.
  - Simultaneous push+pop in EMPTY is impossible, since m_valid=0.
- Outputs:
  - m_valid = (count!=0).
  - m_data = buf[rd_sel], registered and stable while m_valid=1 and m_ready=0.
  - occupancy = count.
- Latency: fifo_rempty falls before edge N with buffer not FULL → fifo_rinc=1 in the cycle before edge N → m_valid=1 after edge N (1 cycle).
- Steady state (FIFO non-empty, m_ready=1): count stays ONE, one beat per cycle, no bubbles.
- FULL: fifo_rinc=0 even if m_ready=1 that cycle; the next cycle returns to ONE and resumes. The 1-cycle bubble is accepted only after a stall.
- FIFO empty: fifo_rinc=0; buffered beats keep draining normally.
- flush=1 at an edge: count=0, wr_sel=rd_sel=0, no pop counted, no FIFO read that cycle. Buffer contents are not cleared (don't care), m_valid=0 next cycle. FIFO contents are untouched.
- Ordering: beats leave in exactly FIFO order; no duplicates, no drops except by flush.
- Reset mid-transfer: all buffered beats are lost. The FIFO pointer is unaffected beyond reads already committed.

Optional Feature:
- Macro: RD_STREAM_CNT_EN.
- Defined:
  - Adds output beat_cnt (16-bit).
  - Reset 0; increments by 1 on each pop, wraps 0xFFFF→0x0000.
  - Unaffected by flush.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset → m_valid=0, m_data=0, occupancy=0, fifo_rinc=0 while rrst=1, even with fifo_rempty=0.
- FIFO holds 0x11,0x22,0x33, m_ready=1 constantly:
  - fifo_rinc high for 3 consecutive cycles.
  - m_data 0x11,0x22,0x33 on 3 consecutive cycles, first one cycle after the first fifo_rinc.
  - occupancy peaks at 1.
- FIFO holds 0xA0..0xA4, m_ready=0:
  - Exactly 2 reads occur, occupancy=2, fifo_rinc=0, m_data held at 0xA0.
  - Then m_ready=1: output 0xA0..0xA4 in order; exactly one bubble at the first FULL cycle.
- occupancy=2 (0x5A,0x5B) with FIFO non-empty; assert flush 1 cycle with m_ready=1:
  - Next cycle m_valid=0, occupancy=0, fifo_rinc=0 in the flush cycle.
  - Streaming then resumes with the next FIFO word.
- Random fifo_rempty/m_ready for 10k cycles against a scoreboard:
  - Output sequence equals FIFO read sequence.
  - occupancy never 3; m_data stable whenever m_valid & ~m_ready.
- With RD_STREAM_CNT_EN: preload beat_cnt region by streaming 65537 beats → beat_cnt=1 (wrap); flush does not change beat_cnt.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - registered valid/ready read stage behind a dual-clock FIFO
// Optional beat counter output enabled by macro RD_STREAM_CNT_EN.
module fifo_rd_stream #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             fifo_rempty,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             fifo_rinc,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
`ifdef RD_STREAM_CNT_EN
  output logic [15:0]      beat_cnt,
`endif
  output logic [1:0]       occupancy
);

  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             wr_sel;
  logic             rd_sel;
  logic             wr_sel_next;
  logic             rd_sel_next;
  logic [DSIZE-1:0] buf0;
  logic [DSIZE-1:0] buf1;
  logic [DSIZE-1:0] data_next;
  logic             push;
  logic             pop;

  // Read the FIFO only from registered state so m_ready never reaches fifo_rinc.
  always_comb begin
    push = ~rrst & ~fifo_rempty & ~flush & (count != 2'd2);
    pop  = m_valid & m_ready & ~flush;
  end

  assign fifo_rinc = push;
  assign occupancy = count;

  // Next-state pointers and count; flush returns the buffer to an empty, aligned state.
  always_comb begin
    count_next  = count;
    wr_sel_next = wr_sel ^ push;
    rd_sel_next = rd_sel ^ pop;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end
    if (flush) begin
      count_next  = 2'd0;
      wr_sel_next = 1'b0;
      rd_sel_next = 1'b0;
    end
  end

  // Head word as it will look after this edge; a push into the head slot bypasses the buffer.
  always_comb begin
    if (push && (wr_sel == rd_sel_next)) begin
      data_next = fifo_rdata;
    end else if (rd_sel_next) begin
      data_next = buf1;
    end else begin
      data_next = buf0;
    end
  end

  // Buffer storage, pointers, count and registered stream outputs.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      count   <= 2'd0;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      buf0    <= '0;
      buf1    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (push && !wr_sel) begin
        buf0 <= fifo_rdata;
      end
      if (push && wr_sel) begin
        buf1 <= fifo_rdata;
      end
      count   <= count_next;
      wr_sel  <= wr_sel_next;
      rd_sel  <= rd_sel_next;
      m_valid <= (count_next != 2'd0);
      m_data  <= data_next;
    end
  end

`ifdef RD_STREAM_CNT_EN
  // Count delivered beats; wraps naturally and ignores flush.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      beat_cnt <= 16'd0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed and scoreboard bench for fifo_rd_stream
module tb_fifo_rd_stream;

  logic       rclk;
  logic       rrst;
  logic       fifo_rempty;
  logic [7:0] fifo_rdata;
  logic       fifo_rinc;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occupancy;
`ifdef RD_STREAM_CNT_EN
  logic [15:0] beat_cnt;
`endif

  fifo_rd_stream #(.DSIZE(8)) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .fifo_rempty (fifo_rempty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rinc   (fifo_rinc),
    .flush       (flush),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
`ifdef RD_STREAM_CNT_EN
    .beat_cnt    (beat_cnt),
`endif
    .occupancy   (occupancy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       hold = 1'b0;
  logic       ready = 1'b0;
  logic       flush_r = 1'b0;
  logic       auto_fill = 1'b0;
  logic [7:0] next_word = 8'h00;
  int         pops = 0;

  logic       s_rinc;
  logic       s_valid;
  logic [7:0] s_data;
  logic [1:0] s_occ;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, sample before the edge, retire FIFO reads after it.
  task automatic cyc();
    @(negedge rclk);
    if (auto_fill) begin
      while (fifo_q.size() < 4) begin
        fifo_q.push_back(next_word);
        next_word = next_word + 8'h01;
      end
    end
    fifo_rempty = hold || (fifo_q.size() == 0);
    fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    m_ready     = ready;
    flush       = flush_r;
    #1;
    s_rinc  = fifo_rinc;
    s_valid = m_valid;
    s_data  = m_data;
    s_occ   = occupancy;
    if (s_occ == 2'd3) check("occ_not3", 32'(s_occ), 32'd2);
    if (s_valid != (s_occ != 2'd0)) check("valid_vs_occ", 32'(s_valid), 32'(s_occ != 2'd0));
    if (prev_hold) check("data_stable", 32'(s_data), 32'(prev_data));
    if (s_valid && ready && !flush_r) begin
      pops++;
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("sb_data", 32'(s_data), 32'(exp_q.pop_front()));
    end
    if (flush_r) exp_q.delete();
    if (s_rinc) exp_q.push_back(fifo_rdata);
    prev_hold = s_valid && !ready && !flush_r;
    prev_data = s_data;
    @(posedge rclk);
    #1;
    if (s_rinc) void'(fifo_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    fifo_q.push_back(8'h77);
    fifo_rempty = 1'b0;
    fifo_rdata  = 8'h77;
    m_ready = 1'b1;
    flush   = 1'b0;
    #1;
    check("rst_rinc", 32'(fifo_rinc), 32'd0);
    @(negedge rclk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_rinc2", 32'(fifo_rinc), 32'd0);
    fifo_q.delete();
    fifo_rempty = 1'b1;
    rrst = 1'b0;
    prev_hold = 1'b0;
    pops = 0;
  endtask

  initial begin
    rrst = 1'b1;
    fifo_rempty = 1'b1;
    fifo_rdata = 8'h00;
    flush = 1'b0;
    m_ready = 1'b0;
    do_reset();

    // Streaming 0x11,0x22,0x33 with the consumer always ready
    fifo_q = '{8'h11, 8'h22, 8'h33};
    ready = 1'b1;
    cyc();
    check("t1_rinc0", 32'(s_rinc), 32'd1);
    check("t1_valid0", 32'(s_valid), 32'd0);
    cyc();
    check("t1_rinc1", 32'(s_rinc), 32'd1);
    check("t1_data1", 32'(s_data), 32'h11);
    check("t1_occ1", 32'(s_occ), 32'd1);
    cyc();
    check("t1_rinc2", 32'(s_rinc), 32'd1);
    check("t1_data2", 32'(s_data), 32'h22);
    check("t1_occ2", 32'(s_occ), 32'd1);
    cyc();
    check("t1_rinc3", 32'(s_rinc), 32'd0);
    check("t1_data3", 32'(s_data), 32'h33);
    cyc();
    check("t1_valid4", 32'(s_valid), 32'd0);

    // Stall fills the buffer, then drain with a single read bubble
    fifo_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    ready = 1'b0;
    repeat (5) cyc();
    check("t2_occ", 32'(s_occ), 32'd2);
    check("t2_rinc", 32'(s_rinc), 32'd0);
    check("t2_data", 32'(s_data), 32'hA0);
    check("t2_reads", fifo_q.size(), 32'd3);
    ready = 1'b1;
    cyc();
    check("t2_bubble", 32'(s_rinc), 32'd0);
    check("t2_d0", 32'(s_data), 32'hA0);
    cyc();
    check("t2_resume", 32'(s_rinc), 32'd1);
    check("t2_d1", 32'(s_data), 32'hA1);
    cyc();
    check("t2_d2", 32'(s_data), 32'hA2);
    cyc();
    check("t2_d3", 32'(s_data), 32'hA3);
    cyc();
    check("t2_d4", 32'(s_data), 32'hA4);
    check("t2_v4", 32'(s_valid), 32'd1);
    cyc();
    check("t2_empty", 32'(s_valid), 32'd0);

    // Flush with two beats buffered and the FIFO still non-empty
    fifo_q = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    ready = 1'b0;
    repeat (3) cyc();
    check("t3_occ2", 32'(s_occ), 32'd2);
    flush_r = 1'b1;
    ready = 1'b1;
    cyc();
    check("t3_flush_rinc", 32'(s_rinc), 32'd0);
    flush_r = 1'b0;
    cyc();
    check("t3_valid", 32'(s_valid), 32'd0);
    check("t3_occ0", 32'(s_occ), 32'd0);
    check("t3_rinc", 32'(s_rinc), 32'd1);
    cyc();
    check("t3_resume", 32'(s_data), 32'h5C);
    cyc();
    check("t3_next", 32'(s_data), 32'h5D);
    cyc();

    // Random empty/ready pattern against the scoreboard
    auto_fill = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      hold  = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 9) < 7);
      cyc();
    end
    auto_fill = 1'b0;
    hold = 1'b0;
    ready = 1'b1;
    fifo_q.delete();
    repeat (6) cyc();
    check("rand_drained", exp_q.size(), 32'd0);
    check("rand_idle", 32'(s_valid), 32'd0);

`ifdef RD_STREAM_CNT_EN
    // Beat counter wraps after 65536 beats and ignores flush
    do_reset();
    check("cnt_rst", 32'(beat_cnt), 32'd0);
    auto_fill = 1'b1;
    ready = 1'b1;
    while (pops < 65537) cyc();
    ready = 1'b0;
    check("cnt_wrap", 32'(beat_cnt), 32'd1);
    flush_r = 1'b1;
    cyc();
    flush_r = 1'b0;
    cyc();
    check("cnt_flush", 32'(beat_cnt), 32'd1);
    auto_fill = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
